// File: rtl/seg7_pkg.sv
// Shared types, glyph constants and the hex-to-segment lookup for the
// 7-segment scan driver (active-low segments, bit0 = a ... bit6 = g).
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin16_to_bcd.sv
// Sequential double-dabble: 16 one-bit iterations into a 5-digit BCD
// accumulator, followed by a one-cycle DONE state that pulses done.
module bin16_to_bcd
  import seg7_pkg::*;
(
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd
);

  bcd_state_t  state;
  logic [15:0] shreg;
  logic [3:0]  iter;
  logic [19:0] adj;

  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      shreg <= '0;
      iter  <= '0;
      bcd   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= bin;
            bcd   <= '0;
            iter  <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bcd   <= {adj[18:0], shreg[15]};
          shreg <= {shreg[14:0], 1'b0};
          iter  <= iter + 4'd1;
          if (iter == 4'd15) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Captures a 16-bit value as hex or decimal, holds it in a 4-digit glyph
// register and scans it onto a common-anode 7-segment display.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned REFRESH_HZ    = 1_000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        hex_mode,
  output logic        busy,
  output logic        ovf,
  output logic [6:0]  displayer,
  output logic [3:0]  digit_selector
);

  localparam int unsigned TICK = CLK_HZ / (REFRESH_HZ * 4);
  localparam int unsigned TW   = (TICK > 1) ? $clog2(TICK) : 1;

  generate
    if (TICK < 1) begin : g_tick_check
      $error("seg7_scan_driver: CLK_HZ/(REFRESH_HZ*4) must be at least 1");
    end
  endgenerate

  logic        start;
  logic        done;
  logic [19:0] bcd;
  logic        hex_pend;
  logic [15:0] hex_val;
  logic [6:0]  disp    [4];
  logic [6:0]  dec_seg [4];
  logic [TW-1:0] tick;
  logic [1:0]  idx;
  logic [1:0]  next_idx;
  logic        wrap;

  assign start = load & ~hex_mode & ~busy;

  bin16_to_bcd u_bcd (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .start      (start),
    .bin        (value),
    .busy       (busy),
    .done       (done),
    .bcd        (bcd)
  );

  // Blank digits 3..1 until the first non-zero digit seen from the left.
  always_comb begin
    logic lead;
    lead = 1'b1;
    for (int unsigned i = 0; i < 4; i++) dec_seg[i] = hex_to_seg(bcd[4*i +: 4]);
    for (int unsigned i = 3; i >= 1; i--) begin
      if (BLANK_LEADING && lead && (bcd[4*i +: 4] == 4'd0)) dec_seg[i] = SEG_BLANK;
      else lead = 1'b0;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      ovf      <= 1'b0;
      hex_pend <= 1'b0;
      hex_val  <= '0;
      for (int unsigned i = 0; i < 4; i++) disp[i] <= hex_to_seg(4'h0);
    end else begin
      hex_pend <= load & hex_mode & ~busy;
      if (load & hex_mode & ~busy) hex_val <= value;
      if (hex_pend) begin
        ovf <= 1'b0;
        for (int unsigned i = 0; i < 4; i++) disp[i] <= hex_to_seg(hex_val[4*i +: 4]);
      end else if (done) begin
        ovf <= (bcd[19:16] != 4'd0);
        for (int unsigned i = 0; i < 4; i++)
          disp[i] <= (bcd[19:16] != 4'd0) ? SEG_DASH : dec_seg[i];
      end
    end
  end

  assign wrap     = (tick == TW'(TICK - 1));
  assign next_idx = wrap ? idx + 2'd1 : idx;

  // Anode and segment registers share next_idx so they switch on the same edge.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      tick           <= '0;
      idx            <= '0;
      digit_selector <= 4'b1110;
      displayer      <= 7'b1000000;
    end else begin
      tick           <= wrap ? '0 : tick + TW'(1);
      idx            <= next_idx;
      digit_selector <= ~(4'b0001 << next_idx);
      displayer      <= disp[next_idx];
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random
// loads, compared against an arithmetic reference model every cycle.
module tb_seg7_scan_driver;

  localparam int unsigned TICK = 4;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        hex_mode = 1'b0;
  logic        busy, ovf;
  logic [6:0]  displayer;
  logic [3:0]  digit_selector;

  int checks = 0;
  int failures = 0;

  logic [6:0]  m_disp [4];
  bit          m_ovf;
  int          conv_left;
  int unsigned conv_val;
  bit          hex_pend;
  logic [15:0] hex_val;
  int          k;
  logic [3:0]  e_sel;
  logic [6:0]  e_seg;

  seg7_scan_driver #(
    .CLK_HZ        (400),
    .REFRESH_HZ    (25),
    .BLANK_LEADING (1'b1)
  ) dut (
    .clk_100MHz     (clk),
    .reset_n        (reset_n),
    .value          (value),
    .load           (load),
    .hex_mode       (hex_mode),
    .busy           (busy),
    .ovf            (ovf),
    .displayer      (displayer),
    .digit_selector (digit_selector)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_disp[i] = GLYPH[0];
    m_ovf = 0; conv_left = 0; hex_pend = 0; hex_val = '0; k = 0;
    e_sel = 4'b1110; e_seg = 7'b1000000;
  endtask

  task automatic commit_dec(input int unsigned v);
    int unsigned pw;
    if (v > 9999) begin
      m_ovf = 1;
      for (int i = 0; i < 4; i++) m_disp[i] = DASH;
    end else begin
      m_ovf = 0;
      pw = 1;
      for (int i = 0; i < 4; i++) begin
        m_disp[i] = (i > 0 && v < pw) ? BLANK : GLYPH[(v / pw) % 10];
        pw = pw * 10;
      end
    end
  endtask

  task automatic model_edge(input bit ld, input logic [15:0] v, input bit hx);
    bit accept;
    int idx;
    accept = ld && (conv_left == 0);
    k++;
    idx = (k / TICK) % 4;
    e_sel = ~(4'b0001 << idx);
    e_seg = m_disp[idx];
    if (hex_pend) begin
      for (int i = 0; i < 4; i++) m_disp[i] = GLYPH[(hex_val >> (4 * i)) & 16'hF];
      m_ovf = 0;
      hex_pend = 0;
    end
    if (conv_left > 0) begin
      conv_left--;
      if (conv_left == 0) commit_dec(conv_val);
    end
    if (accept) begin
      if (hx) begin hex_pend = 1; hex_val = v; end
      else begin conv_left = 17; conv_val = v; end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".busy"}, busy, conv_left > 0);
    check_eq({tag, ".ovf"}, ovf, m_ovf);
    check_eq({tag, ".sel"}, digit_selector, e_sel);
    check_eq({tag, ".seg"}, displayer, e_seg);
  endtask

  task automatic step(input bit ld, input logic [15:0] v, input bit hx, input string tag);
    load = ld; value = v; hex_mode = hx;
    @(posedge clk);
    model_edge(ld, v, hx);
    @(negedge clk);
    load = 1'b0;
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) step(0, 16'h0, 0, tag);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check_outputs("rst_hold");
    end
    reset_n = 1'b1;
  endtask

  // Walk a full frame and compare each scanned digit against fixed glyphs.
  task automatic check_frame(input logic [6:0] d3, input logic [6:0] d2,
                             input logic [6:0] d1, input logic [6:0] d0, input string tag);
    for (int c = 0; c < 4 * TICK; c++) begin
      step(0, 16'h0, 0, tag);
      case (digit_selector)
        4'b1110: check_eq({tag, ".d0"}, displayer, d0);
        4'b1101: check_eq({tag, ".d1"}, displayer, d1);
        4'b1011: check_eq({tag, ".d2"}, displayer, d2);
        4'b0111: check_eq({tag, ".d3"}, displayer, d3);
        default: check_eq({tag, ".onehot"}, digit_selector, 4'b1110);
      endcase
    end
  endtask

  initial begin
    logic [3:0] sel_seq [4];
    sel_seq[0] = 4'b1110; sel_seq[1] = 4'b1101; sel_seq[2] = 4'b1011; sel_seq[3] = 4'b0111;

    @(negedge clk);
    do_reset(5);
    check_eq("rst.sel_const", digit_selector, 4'b1110);
    check_eq("rst.seg_const", displayer, 7'b1000000);
    for (int j = 1; j <= 16; j++) begin
      step(0, 16'h0, 0, "scan");
      if (j % 4 == 0) check_eq("scan_seq", digit_selector, sel_seq[(j / 4) % 4]);
    end

    step(1, 16'd1234, 0, "dec1234");
    check_eq("dec1234.busy_const", busy, 1'b1);
    idle(16, "dec1234_wait");
    check_eq("dec1234.busy_last", busy, 1'b1);
    step(0, 16'h0, 0, "dec1234_done");
    check_eq("dec1234.busy_clear", busy, 1'b0);
    check_frame(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, "frame1234");
    check_eq("dec1234.ovf", ovf, 1'b0);

    step(1, 16'd12345, 0, "dec12345");
    idle(18, "dec12345_wait");
    check_eq("dec12345.ovf", ovf, 1'b1);
    check_frame(DASH, DASH, DASH, DASH, "frame12345");
    step(1, 16'h00BE, 1, "hex00BE");
    check_eq("hex00BE.busy", busy, 1'b0);
    step(0, 16'h0, 0, "hex00BE_commit");
    check_eq("hex00BE.ovf", ovf, 1'b0);
    check_frame(GLYPH[0], GLYPH[0], GLYPH[11], GLYPH[14], "frame00BE");

    step(1, 16'd7, 0, "dec7");
    idle(18, "dec7_wait");
    check_frame(BLANK, BLANK, BLANK, 7'b1111000, "frame7");
    step(1, 16'd9999, 0, "dec9999");
    idle(18, "dec9999_wait");
    check_eq("dec9999.ovf", ovf, 1'b0);
    check_frame(GLYPH[9], GLYPH[9], GLYPH[9], GLYPH[9], "frame9999");
    step(1, 16'd10000, 0, "dec10000");
    idle(18, "dec10000_wait");
    check_eq("dec10000.ovf", ovf, 1'b1);
    check_frame(DASH, DASH, DASH, DASH, "frame10000");

    step(1, 16'd4321, 0, "dec4321");
    idle(4, "dec4321_wait");
    step(1, 16'd5678, 0, "drop5678");
    idle(16, "dec4321_rest");
    check_frame(GLYPH[4], GLYPH[3], GLYPH[2], GLYPH[1], "frame4321");

    step(1, 16'd8765, 0, "abort");
    idle(7, "abort_wait");
    do_reset(2);
    idle(30, "abort_after");
    check_eq("abort.ovf", ovf, 1'b0);
    check_frame(GLYPH[0], GLYPH[0], GLYPH[0], GLYPH[0], "frame_abort");

    for (int r = 0; r < 30; r++) begin
      logic [15:0] v;
      int unsigned kind;
      kind = $urandom_range(0, 3);
      v = 16'($urandom);
      if (kind == 0) v = 16'($urandom_range(0, 9999));
      if (kind == 1) v = 16'($urandom_range(0, 120));
      step(1, v, kind == 3, "rand");
      idle($urandom_range(0, 24), "rand_gap");
    end
    idle(20, "tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
